// File: rtl/btree_pkg.sv
// rtl/btree_pkg.sv - shared types and node word layout helpers for the B-tree search engine
// Node word, LSB first: count | key[0..KEYS-1] | data[0..KEYS-1] | next[0..KEYS].
package btree_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic int cb_bits(input int keys);
        return $clog2(keys + 1);
    endfunction

    function automatic int node_bits(input int keys, input int kb, input int db, input int ab);
        return cb_bits(keys) + keys * (kb + db) + (keys + 1) * ab;
    endfunction

    function automatic int key_off(input int keys, input int kb, input int i);
        return cb_bits(keys) + i * kb;
    endfunction

    function automatic int data_off(input int keys, input int kb, input int db, input int i);
        return cb_bits(keys) + keys * kb + i * db;
    endfunction

    function automatic int next_off(input int keys, input int kb, input int db, input int ab,
                                    input int i);
        return cb_bits(keys) + keys * (kb + db) + i * ab;
    endfunction

endpackage

// File: rtl/btree_find_if.sv
// rtl/btree_find_if.sv - search request/result and node memory signals of btree_find
// slave: the search engine; master: the requester plus node memory.
interface btree_find_if
    import btree_pkg::*;
#(
    parameter int KEY_BITS  = 4,
    parameter int DATA_BITS = 4,
    parameter int ADDR_BITS = 8,
    parameter int NODE_BITS = node_bits(3, 4, 4, 8),
    parameter int STEP_BITS = 4
);
    logic                 start;
    logic [KEY_BITS-1:0]  key;
    logic                 ready;
    logic                 done;
    logic                 found;
    logic [DATA_BITS-1:0] data;
    logic                 error;
    logic [STEP_BITS-1:0] steps;
    logic                 mem_read;
    logic [ADDR_BITS-1:0] mem_address;
    logic [NODE_BITS-1:0] mem_data;

    modport slave (
        input  start, key, mem_data,
        output ready, done, found, data, error, steps, mem_read, mem_address
    );

    modport master (
        output start, key, mem_data,
        input  ready, done, found, data, error, steps, mem_read, mem_address
    );
endinterface

// File: rtl/btree_node_compare.sv
// rtl/btree_node_compare.sv - combinational key lookup within one B-tree node word
// Inputs: node word, search key. Outputs: match, match_idx, match_data, child_idx, child_addr.
module btree_node_compare
    import btree_pkg::*;
#(
    parameter int KEYS      = 3,
    parameter int KEY_BITS  = 4,
    parameter int DATA_BITS = 4,
    parameter int ADDR_BITS = 8,
    localparam int CB = cb_bits(KEYS),
    localparam int NB = node_bits(KEYS, KEY_BITS, DATA_BITS, ADDR_BITS)
) (
    input  logic [NB-1:0]        node,
    input  logic [KEY_BITS-1:0]  key,
    output logic                 match,
    output logic [CB-1:0]        match_idx,
    output logic [DATA_BITS-1:0] match_data,
    output logic [CB-1:0]        child_idx,
    output logic [ADDR_BITS-1:0] child_addr
);
    always_comb begin
        int cnt;
        // Counts wider than the node holds are clamped, so stale slots stay invisible.
        cnt = int'(node[CB-1:0]);
        if (cnt > KEYS) cnt = KEYS;

        match      = 1'b0;
        match_idx  = '0;
        match_data = '0;
        child_idx  = '0;
        child_addr = '0;

        // Scan downward so the lowest matching slot is the one that sticks.
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (i < cnt && node[key_off(KEYS, KEY_BITS, i) +: KEY_BITS] == key) begin
                match      = 1'b1;
                match_idx  = CB'(i);
                match_data = node[data_off(KEYS, KEY_BITS, DATA_BITS, i) +: DATA_BITS];
            end
        end

        for (int i = 0; i < KEYS; i++) begin
            if (i < cnt && node[key_off(KEYS, KEY_BITS, i) +: KEY_BITS] < key)
                child_idx = child_idx + CB'(1);
        end

        for (int i = 0; i <= KEYS; i++) begin
            if (CB'(i) == child_idx)
                child_addr = node[next_off(KEYS, KEY_BITS, DATA_BITS, ADDR_BITS, i) +: ADDR_BITS];
        end
    end
endmodule

// File: rtl/btree_find.sv
// rtl/btree_find.sv - sequential B-tree search walker, one node read per level
// Ports: clk, rst (async, active-high), bus (btree_find_if.slave: start/key/ready/done/
// found/data/error/steps request side, mem_read/mem_address/mem_data node memory side).
module btree_find
    import btree_pkg::*;
#(
    parameter int KEYS      = 3,
    parameter int KEY_BITS  = 4,
    parameter int DATA_BITS = 4,
    parameter int ADDR_BITS = 8,
    parameter int ROOT      = 1,
    parameter int MAX_STEPS = 8
) (
    input  logic         clk,
    input  logic         rst,
    btree_find_if.slave  bus
);
    localparam int STEP_BITS = $clog2(MAX_STEPS + 1);
    localparam int CB        = cb_bits(KEYS);

    state_t state, state_n;

    logic [KEY_BITS-1:0]  key_q;
    logic [ADDR_BITS-1:0] address;
    logic [STEP_BITS-1:0] steps_q;
    logic                 done_q, found_q, error_q;
    logic [DATA_BITS-1:0] data_q;

    logic                 hit;
    logic [CB-1:0]        hit_idx;
    logic [DATA_BITS-1:0] hit_data;
    logic [CB-1:0]        child_idx;
    logic [ADDR_BITS-1:0] child_addr;
    logic                 at_limit;

    btree_node_compare #(
        .KEYS      (KEYS),
        .KEY_BITS  (KEY_BITS),
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_compare (
        .node       (bus.mem_data),
        .key        (key_q),
        .match      (hit),
        .match_idx  (hit_idx),
        .match_data (hit_data),
        .child_idx  (child_idx),
        .child_addr (child_addr)
    );

    // steps already counts the read whose word is being checked.
    assign at_limit = (steps_q == STEP_BITS'(MAX_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = READ;
            READ:    state_n = CHECK;
            CHECK:   if (hit || child_addr == '0 || at_limit) state_n = IDLE;
                     else state_n = READ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            address <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    key_q   <= bus.key;
                    address <= ADDR_BITS'(ROOT);
                    steps_q <= '0;
                    found_q <= 1'b0;
                    data_q  <= '0;
                    error_q <= 1'b0;
                end
                READ: steps_q <= steps_q + STEP_BITS'(1);
                CHECK: begin
                    if (hit) begin
                        done_q  <= 1'b1;
                        found_q <= 1'b1;
                        data_q  <= hit_data;
                    end else if (child_addr == '0) begin
                        done_q  <= 1'b1;
                    end else if (at_limit) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        address <= child_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Index sanity on the words actually inspected; other cycles see don't-care memData.
    assert property (@(posedge clk) disable iff (rst)
        (state == CHECK && hit) |-> (int'(hit_idx) < KEYS));
    assert property (@(posedge clk) disable iff (rst)
        (state == CHECK) |-> (int'(child_idx) <= KEYS));

    assign bus.ready       = (state == IDLE);
    assign bus.mem_read    = (state == READ);
    assign bus.mem_address = address;
    assign bus.done        = done_q;
    assign bus.found       = found_q;
    assign bus.data        = data_q;
    assign bus.error       = error_q;
    assign bus.steps       = steps_q;
endmodule

// File: tb/tb_btree_find.sv
// tb/tb_btree_find.sv - directed self-checking bench for btree_find
module tb_btree_find;
    import btree_pkg::*;

    localparam int NB = node_bits(3, 4, 4, 8);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btree_find_if #(.NODE_BITS(NB), .STEP_BITS(4)) bus_a ();
    btree_find_if #(.NODE_BITS(NB), .STEP_BITS(3)) bus_b ();

    btree_find dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    btree_find #(.MAX_STEPS(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [NB-1:0] mem [0:15];

    always @(posedge clk) if (bus_a.mem_read) bus_a.mem_data <= mem[bus_a.mem_address[3:0]];
    always @(posedge clk) if (bus_b.mem_read) bus_b.mem_data <= mem[bus_b.mem_address[3:0]];

    int checks = 0;
    int errors = 0;
    logic [7:0] addrs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] node(input logic [1:0] c,
        input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
        input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
        input logic [7:0] n0, input logic [7:0] n1, input logic [7:0] n2, input logic [7:0] n3);
        return {n3, n2, n1, n0, d2, d1, d0, k2, k1, k0, c};
    endfunction

    task automatic sample_read(input int which);
        if (which == 0 && bus_a.mem_read) addrs.push_back(bus_a.mem_address);
        if (which == 1 && bus_b.mem_read) addrs.push_back(bus_b.mem_address);
    endtask

    // Returns the number of edges from the accepting edge to the edge that raised done.
    task automatic search(input int which, input logic [3:0] k, output int lat);
        @(negedge clk);
        if (which == 0) begin bus_a.start = 1'b1; bus_a.key = k; end
        else            begin bus_b.start = 1'b1; bus_b.key = k; end
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check("ready_low_after_accept", which == 0 ? bus_a.ready : bus_b.ready, 1'b0);
        addrs.delete();
        lat = -1;
        sample_read(which);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if ((which == 0 ? bus_a.done : bus_b.done) == 1'b1) lat = c;
            else sample_read(which);
        end
        check("done_seen", lat >= 0, 1'b1);
    endtask

    int lat;
    int seen;

    initial begin
        bus_a.start = 1'b0; bus_a.key = '0;
        bus_b.start = 1'b0; bus_b.key = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        #12;
        check("rst_ready",    bus_a.ready,       1'b1);
        check("rst_done",     bus_a.done,        1'b0);
        check("rst_found",    bus_a.found,       1'b0);
        check("rst_error",    bus_a.error,       1'b0);
        check("rst_mem_read", bus_a.mem_read,    1'b0);
        check("rst_data",     bus_a.data,        4'h0);
        check("rst_steps",    bus_a.steps,       4'h0);
        check("rst_mem_addr", bus_a.mem_address, 8'h00);
        @(negedge clk); rst = 1'b0;

        // single-level hit
        mem[1] = node(3, 2, 5, 9, 7, 8, 9, 0, 0, 0, 0);
        search(0, 4'd5, lat);
        check("t1_latency", lat, 2);
        check("t1_found",   bus_a.found, 1'b1);
        check("t1_data",    bus_a.data,  4'h8);
        check("t1_steps",   bus_a.steps, 4'd1);
        check("t1_error",   bus_a.error, 1'b0);
        check("t1_ready",   bus_a.ready, 1'b1);
        @(posedge clk); #1;
        check("t1_done_pulse", bus_a.done, 1'b0);
        check("t1_found_hold", bus_a.found, 1'b1);

        // two-level descent through next[1]
        mem[1] = node(3, 4, 8, 12, 0, 0, 0, 2, 3, 4, 5);
        mem[3] = node(2, 6, 7, 0, 4'hA, 4'hB, 0, 0, 0, 0, 0);
        search(0, 4'd6, lat);
        check("t2_latency", lat, 4);
        check("t2_nreads",  addrs.size(), 2);
        if (addrs.size() == 2) begin
            check("t2_addr0", addrs[0], 8'd1);
            check("t2_addr1", addrs[1], 8'd3);
        end
        check("t2_found", bus_a.found, 1'b1);
        check("t2_data",  bus_a.data,  4'hA);
        check("t2_steps", bus_a.steps, 4'd2);

        // absent key at a leaf
        mem[1] = node(2, 6, 9, 0, 1, 2, 0, 0, 0, 0, 0);
        search(0, 4'd7, lat);
        check("t3_found", bus_a.found, 1'b0);
        check("t3_data",  bus_a.data,  4'h0);
        check("t3_error", bus_a.error, 1'b0);
        check("t3_steps", bus_a.steps, 4'd1);

        // stale slot beyond count is not matched
        mem[1] = node(1, 3, 5, 0, 1, 2, 0, 0, 0, 0, 0);
        search(0, 4'd5, lat);
        check("t4_found", bus_a.found, 1'b0);
        check("t4_data",  bus_a.data,  4'h0);

        // count=0 follows next[0] even though key[0] holds the search key
        mem[1] = node(0, 5, 0, 0, 3, 0, 0, 4, 0, 0, 0);
        mem[4] = node(1, 5, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        search(0, 4'd5, lat);
        check("t4b_steps", bus_a.steps, 4'd2);
        check("t4b_found", bus_a.found, 1'b1);
        check("t4b_data",  bus_a.data,  4'h6);

        // depth limit on the MAX_STEPS=4 instance
        mem[1] = node(3, 2, 5, 9, 7, 8, 9, 1, 1, 1, 1);
        search(1, 4'd7, lat);
        check("t5_latency", lat, 8);
        check("t5_error",   bus_b.error, 1'b1);
        check("t5_found",   bus_b.found, 1'b0);
        check("t5_steps",   bus_b.steps, 3'd4);
        check("t5_nreads",  addrs.size(), 4);

        // back-to-back: second start lands in the done cycle of the first
        mem[1] = node(3, 2, 5, 9, 7, 8, 9, 0, 0, 0, 0);
        search(0, 4'd9, lat);
        check("t6a_data", bus_a.data, 4'h9);
        search(0, 4'd2, lat);
        check("t6b_latency", lat, 2);
        check("t6b_data",    bus_a.data, 4'h7);

        // start held into READ with another key is ignored
        @(negedge clk); bus_a.start = 1'b1; bus_a.key = 4'd9;
        @(posedge clk); #1; bus_a.key = 4'd2;
        @(posedge clk); #1; bus_a.start = 1'b0;
        @(posedge clk); #1;
        check("t6c_done",  bus_a.done,  1'b1);
        check("t6c_data",  bus_a.data,  4'h9);
        check("t6c_steps", bus_a.steps, 4'd1);

        // reset in CHECK aborts without done
        @(negedge clk); bus_a.start = 1'b1; bus_a.key = 4'd5;
        @(posedge clk); #1; bus_a.start = 1'b0;
        @(posedge clk); #1;
        check("t6d_ready_busy", bus_a.ready, 1'b0);
        rst = 1'b1; #1;
        check("t6d_rst_ready", bus_a.ready,    1'b1);
        check("t6d_rst_read",  bus_a.mem_read, 1'b0);
        check("t6d_rst_steps", bus_a.steps,    4'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus_a.done) seen++;
        end
        check("t6d_no_done", seen, 0);
        search(0, 4'd5, lat);
        check("t6e_latency", lat, 2);
        check("t6e_data",    bus_a.data, 4'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btree_find.md
# btree_find

Sequential multi-level search engine for the B-tree key/data store. It accepts a search key, then walks nodes from a root address, one node read per level, through a synchronous node memory. It stops on a key match, on a null child (key absent), or on a depth limit (error). It replaces per-node combinational lookup with a parametrised, handshaked walker that honours a per-node valid-key count.

## Interface
- KEYS, 3: keys per node (next fields = KEYS+1)
- KEY_BITS, 4: key width
- DATA_BITS, 4: data width
- ADDR_BITS, 8: node address width; address 0 = null child
- ROOT, 1: root node address, nonzero
- MAX_STEPS, 8: maximum node reads per search
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; accepted only when ready=1
- key  in  KEY_BITS  search key, sampled with an accepted start
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse, result valid
- found  out  1  key matched
- data  out  DATA_BITS  matched data, 0 if not found
- error  out  1  MAX_STEPS reached without resolution
- steps  out  $clog2(MAX_STEPS+1)  nodes read in this search
- memRead  out  1  node read strobe
- memAddress  out  ADDR_BITS  node address
- memData  in  NODE_BITS  node word, valid the cycle after memRead

## Operation
- Node word layout, LSB first:
  - count: CB=$clog2(KEYS+1) bits
  - key[0..KEYS-1]
  - data[0..KEYS-1]
  - next[0..KEYS]
- NODE_BITS = CB + KEYS*(KEY_BITS+DATA_BITS) + (KEYS+1)*ADDR_BITS.
- Slots i >= count are ignored: never matched and never counted. Valid keys are sorted ascending, unsigned. A count above KEYS is clamped to KEYS.
- Match: lowest valid i with key[i]==key gives found=1, data=data[i].
- Child: index j = number of valid keys less than key; follow next[j]. With count=0, follow next[0].
- States:
  - IDLE: ready=1. On start, latch key, set address=ROOT, set steps=0, go to READ.
  - READ: memRead=1 with memAddress=address; steps+1; go to CHECK.
  - CHECK: memData is valid. Decide in this order:
    - match: done with found=1
    - next[j]==0: done with found=0
    - steps==MAX_STEPS: done with error=1
    - otherwise: address=next[j], go to READ
  - Every "done" outcome returns to IDLE and pulses done.
- found, data, error and steps are registered. They hold from done until the next accepted start, which clears them.
- start while ready=0 is ignored. No queueing.

## Timing
- Reset values:
  - state IDLE, ready=1
  - done, found, error, memRead = 0
  - data, steps = 0
  - memAddress = 0
- Reset mid-search aborts immediately. No done is issued.
- Start sampled at edge k: memRead is high in cycle k..k+1. A search resolving at level L raises done for one cycle after edge k+2L.
- ready drops on the edge after an accepted start. It rises on the same edge done rises.
- start may be reasserted in the done cycle and is accepted there. Back-to-back searches therefore have no idle gap.
- memData is sampled only in CHECK. Its value in any other state is don't-care.

## Structure
- Package btree_pkg holds:
  - state enum (IDLE, READ, CHECK)
  - functions for NODE_BITS and field offsets, from KEYS/KEY_BITS/DATA_BITS/ADDR_BITS
- Sub-module btree_node_compare (combinational): node word + key in; match, match index, data, child index j, child address out.
- The FSM, counters and output registers stay in btree_find.

## Test plan
Defaults are used unless stated.
1. Root@1: count=3, keys 2/5/9, data 7/8/9, nexts 0. Search 5 → done 2 cycles after start, found=1, data=8, steps=1.
2. Root@1: keys 4/8/12, nexts 2/3/4/5. Node@3: count=2, keys 6/7, data A/B. Search 6 → memAddress 1 then 3, found=1, data=A, steps=2, latency 4.
3. Leaf@1: count=2, keys 6/9, nexts 0. Search 7 → found=0, data=0, error=0, steps=1.
4. Node@1: count=1, key[0]=3, stale key[1]=5, next[1]=0. Search 5 → found=0; the stale slot is not matched.
5. Node@1 with all nexts=1, MAX_STEPS=4, search absent key → error=1, steps=4, done after 8 cycles.
6. start pulsed during READ → ignored. Reset asserted in CHECK → ready=1 and memRead=0 immediately, no done. A new search afterwards completes normally.
